// File: rtl/coco_regfile_sb.sv
// coco_regfile_sb: parametrised single-write, dual-read register file with a
// per-register scoreboard. Decode reads operands and issues producers; writeback
// writes results and clears the pending flag. A stall request is raised when a
// consumed operand is still pending.
module coco_regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  // Read port 1
  input  logic [ADDR_W-1:0] RS1,
  output logic [DATA_W-1:0] RData1,
  output logic              RReady1,
  input  logic              RUse1,
  // Read port 2
  input  logic [ADDR_W-1:0] RS2,
  output logic [DATA_W-1:0] RData2,
  output logic              RReady2,
  input  logic              RUse2,
  // Decode stall request
  output logic              StallReq,
  // Writeback port
  input  logic [ADDR_W-1:0] RD,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] WData,
  // Issue port
  input  logic              IssueEn,
  input  logic [ADDR_W-1:0] IssueRD,
  // Scoreboard occupancy
  output logic [ADDR_W:0]   BusyCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] reg_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic wr_en;
  logic iss_en;

  // Qualified write/issue enables; the hardwired zero register swallows both.
  always_comb begin
    wr_en  = RegWrite;
    iss_en = IssueEn;
    if (ZERO_REG && (RD == '0)) begin
      wr_en = 1'b0;
    end
    if (ZERO_REG && (IssueRD == '0)) begin
      iss_en = 1'b0;
    end
  end

  // Next busy vector: write clears, issue sets; issue applied last so the
  // younger producer wins on a same-register collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[RD] = 1'b0;
    end
    if (iss_en) begin
      busy_d[IssueRD] = 1'b1;
    end
  end

  // Popcount of the post-update busy vector, registered into BusyCount.
  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Scoreboard state and occupancy counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Register array storage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
      end
    end else if (wr_en) begin
      reg_q[RD] <= WData;
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then array/scoreboard.
  // Gated by reset so an in-flight write cannot leak through the bypass.
  always_comb begin
    RData1  = reg_q[RS1];
    RReady1 = ~busy_q[RS1];
    if (!Reset_n) begin
      RData1  = '0;
      RReady1 = 1'b1;
    end else if (ZERO_REG && (RS1 == '0)) begin
      RData1  = '0;
      RReady1 = 1'b1;
    end else if (BYPASS && wr_en && (RD == RS1)) begin
      RData1  = WData;
      RReady1 = 1'b1;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    RData2  = reg_q[RS2];
    RReady2 = ~busy_q[RS2];
    if (!Reset_n) begin
      RData2  = '0;
      RReady2 = 1'b1;
    end else if (ZERO_REG && (RS2 == '0)) begin
      RData2  = '0;
      RReady2 = 1'b1;
    end else if (BYPASS && wr_en && (RD == RS2)) begin
      RData2  = WData;
      RReady2 = 1'b1;
    end
  end

  // Stall only on operands decode actually consumes.
  always_comb begin
    StallReq = (RUse1 & ~RReady1) | (RUse2 & ~RReady2);
  end

  assign BusyCount = busy_cnt_q;

endmodule

// File: tb/tb_coco_regfile_sb.sv
// Self-checking bench for coco_regfile_sb (default parameters: 32-bit data,
// 32 registers, bypass on, hardwired zero register). Directed scenarios first,
// then randomized traffic checked against a simple array/flag reference model.
module tb_coco_regfile_sb;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  RS1, RS2, RD, IssueRD;
  logic [31:0] RData1, RData2, WData;
  logic        RReady1, RReady2, RUse1, RUse2;
  logic        StallReq, RegWrite, IssueEn;
  logic [5:0]  BusyCount;

  int checks;
  int errors;

  // Reference model state
  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  coco_regfile_sb dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .RS1      (RS1),
    .RData1   (RData1),
    .RReady1  (RReady1),
    .RUse1    (RUse1),
    .RS2      (RS2),
    .RData2   (RData2),
    .RReady2  (RReady2),
    .RUse2    (RUse2),
    .StallReq (StallReq),
    .RD       (RD),
    .RegWrite (RegWrite),
    .WData    (WData),
    .IssueEn  (IssueEn),
    .IssueRD  (IssueRD),
    .BusyCount(BusyCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0;
    IssueEn  = 1'b0;
    RUse1    = 1'b0;
    RUse2    = 1'b0;
    RD       = '0;
    IssueRD  = '0;
    WData    = '0;
  endtask

  // Expected read result from the model under the given same-cycle write.
  function automatic void model_read(input logic [4:0] rs, input logic we, input logic [4:0] rd,
                                     input logic [31:0] wd, output logic [31:0] d,
                                     output logic r);
    if (rs == 0) begin
      d = 0;
      r = 1'b1;
    end else if (we && rd != 0 && rd == rs) begin
      d = wd;
      r = 1'b1;
    end else begin
      d = m_mem[rs];
      r = !m_busy[rs];
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] ed1, ed2;
    logic        er1, er2;
    checks = 0;
    errors = 0;

    // Reset held with a write presented: nothing honoured, outputs forced.
    Reset_n = 1'b0;
    idle_inputs();
    RegWrite = 1'b1; RD = 5'd3; WData = 32'hDEAD;
    RS1 = 5'd3; RS2 = 5'd3; RUse1 = 1'b1; RUse2 = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst_rdata1", RData1, 32'h0);
    chk("rst_rready1", RReady1, 1'b1);
    chk("rst_rready2", RReady2, 1'b1);
    chk("rst_stall", StallReq, 1'b0);
    chk("rst_busycnt", BusyCount, 6'd0);
    Reset_n = 1'b1;
    #1;
    chk("post_rst_bypass", RData1, 32'hDEAD);
    cyc();
    RegWrite = 1'b0; RUse1 = 1'b0; RUse2 = 1'b0;
    #1;
    chk("r3_written", RData1, 32'hDEAD);
    chk("r3_ready", RReady1, 1'b1);

    // Zero register ignores write and issue.
    RegWrite = 1'b1; RD = 5'd0; WData = 32'hFFFF_FFFF;
    IssueEn = 1'b1; IssueRD = 5'd0; RS1 = 5'd0;
    #1;
    chk("zero_same_cyc", RData1, 32'h0);
    cyc();
    idle_inputs();
    #1;
    chk("zero_rdata", RData1, 32'h0);
    chk("zero_ready", RReady1, 1'b1);
    chk("zero_busycnt", BusyCount, 6'd0);

    // Scoreboard stall with bypass on writeback.
    IssueEn = 1'b1; IssueRD = 5'd5; RS2 = 5'd5; RUse2 = 1'b1;
    #1;
    chk("issue_not_visible", RReady2, 1'b1);
    cyc();
    IssueEn = 1'b0;
    #1;
    chk("c1_ready2", RReady2, 1'b0);
    chk("c1_stall", StallReq, 1'b1);
    chk("c1_busycnt", BusyCount, 6'd1);
    cyc();
    #1;
    chk("c2_stall", StallReq, 1'b1);
    cyc();
    RegWrite = 1'b1; RD = 5'd5; WData = 32'h1234;
    #1;
    chk("c3_rdata2", RData2, 32'h1234);
    chk("c3_ready2", RReady2, 1'b1);
    chk("c3_stall", StallReq, 1'b0);
    chk("c3_busycnt", BusyCount, 6'd1);
    cyc();
    RegWrite = 1'b0;
    #1;
    chk("c4_busycnt", BusyCount, 6'd0);
    chk("c4_rdata2", RData2, 32'h1234);
    chk("c4_ready2", RReady2, 1'b1);
    RUse2 = 1'b0;

    // Simultaneous write and issue on a busy register: issue wins.
    IssueEn = 1'b1; IssueRD = 5'd7;
    cyc();
    IssueEn = 1'b1; IssueRD = 5'd7; RegWrite = 1'b1; RD = 5'd7; WData = 32'hAA;
    cyc();
    idle_inputs();
    RS1 = 5'd7;
    #1;
    chk("simul_ready1", RReady1, 1'b0);
    chk("simul_rdata1", RData1, 32'hAA);
    chk("simul_busycnt", BusyCount, 6'd1);
    RegWrite = 1'b1; RD = 5'd7; WData = 32'hAA;
    cyc();
    idle_inputs();
    #1;
    chk("r7_cleared_cnt", BusyCount, 6'd0);

    // Dual port, unused operand does not stall.
    IssueEn = 1'b1; IssueRD = 5'd2; RegWrite = 1'b1; RD = 5'd4; WData = 32'h44;
    cyc();
    idle_inputs();
    RS1 = 5'd2; RUse1 = 1'b0; RS2 = 5'd4; RUse2 = 1'b1;
    #1;
    chk("dual_stall_unused", StallReq, 1'b0);
    chk("dual_rdata2", RData2, 32'h44);
    chk("dual_ready1", RReady1, 1'b0);
    RUse1 = 1'b1;
    #1;
    chk("dual_stall_used", StallReq, 1'b1);

    // Asynchronous reset mid-cycle with three registers busy.
    RUse1 = 1'b0; RUse2 = 1'b0;
    IssueEn = 1'b1; IssueRD = 5'd9;
    cyc();
    IssueRD = 5'd10;
    cyc();
    idle_inputs();
    RS1 = 5'd9; RUse1 = 1'b1;
    #1;
    chk("three_busy_cnt", BusyCount, 6'd3);
    chk("three_busy_stall", StallReq, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("async_busycnt", BusyCount, 6'd0);
    chk("async_stall", StallReq, 1'b0);
    chk("async_ready1", RReady1, 1'b1);
    chk("async_rdata1", RData1, 32'h0);
    #1;
    Reset_n = 1'b1;
    #1;
    chk("after_rst_ready1", RReady1, 1'b1);
    chk("after_rst_r4", 64'(dut.RData2), 64'h0);

    // Randomized traffic against the reference model (model starts at reset state).
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    idle_inputs();
    cyc();
    for (int n = 0; n < 300; n++) begin
      RS1      = 5'($urandom_range(0, 7));
      RS2      = 5'($urandom_range(0, 7));
      RD       = 5'($urandom_range(0, 7));
      IssueRD  = 5'($urandom_range(0, 7));
      RegWrite = 1'($urandom_range(0, 1));
      IssueEn  = ($urandom_range(0, 2) == 0);
      RUse1    = 1'($urandom_range(0, 1));
      RUse2    = 1'($urandom_range(0, 1));
      WData    = $urandom;
      #1;
      model_read(RS1, RegWrite, RD, WData, ed1, er1);
      model_read(RS2, RegWrite, RD, WData, ed2, er2);
      chk("rnd_rdata1", RData1, ed1);
      chk("rnd_rready1", RReady1, er1);
      chk("rnd_rdata2", RData2, ed2);
      chk("rnd_rready2", RReady2, er2);
      chk("rnd_stall", StallReq, (RUse1 && !er1) || (RUse2 && !er2));
      chk("rnd_busycnt", BusyCount, 64'(model_count()));
      if (RegWrite && RD != 0) begin
        m_mem[RD]  = WData;
        m_busy[RD] = 1'b0;
      end
      if (IssueEn && IssueRD != 0) m_busy[IssueRD] = 1'b1;
      cyc();
    end
    idle_inputs();
    #1;
    chk("rnd_final_cnt", BusyCount, 64'(model_count()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coco_regfile_sb.md
Name: coco_regfile_sb

Overview:
Parametrised successor to the single-write, two-read CPU register file. It adds configurable data width and depth, optional write-to-read bypass, and a per-register scoreboard that tracks pending producers such as loads and multi-cycle ops. Each read port reports a ready flag, and the block raises a stall request for the decode stage. It sits between decode (reads and issue) and writeback (writes) in the pipeline.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array contents only
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
RS1  input  ADDR_W  read port 1 address
RS2  input  ADDR_W  read port 2 address
RData1  output  DATA_W  read port 1 data (combinational)
RData2  output  DATA_W  read port 2 data (combinational)
RReady1  output  1  RData1 valid: register not pending, or being written this cycle with BYPASS=1
RReady2  output  1  same as RReady1, for port 2
RUse1  input  1  decode actually consumes RS1 this cycle
RUse2  input  1  decode actually consumes RS2 this cycle
StallReq  output  1  (RUse1 & ~RReady1) | (RUse2 & ~RReady2)
RD  input  ADDR_W  write address
RegWrite  input  1  write enable
WData  input  DATA_W  write data
IssueEn  input  1  mark IssueRD as pending (new producer issued)
IssueRD  input  ADDR_W  destination register being issued
BusyCount  output  ADDR_W+1  number of registers currently pending (registered)

Behaviour:
- Storage: array Reg[0..2**ADDR_W-1] of DATA_W bits, plus busy vector Busy[0..2**ADDR_W-1].
- Reset (Reset_n=0, asynchronous):
  - all Reg cleared to 0, all Busy cleared, BusyCount=0.
  - Outputs while in reset: RData=0, RReady=1, StallReq=0.
  - Reset mid-operation discards all pending state. No write or issue is honoured while Reset_n=0.
- Write: on posedge, if RegWrite=1 and not (ZERO_REG=1 and RD=0), then Reg[RD]<=WData and Busy[RD]<=0.
  - With ZERO_REG=0, register 0 is an ordinary register.
- Issue: on posedge, if IssueEn=1 and not (ZERO_REG=1 and IssueRD=0), then Busy[IssueRD]<=1.
- Simultaneous events:
  - Issue and write to the same register in the same cycle: write data is stored and Busy ends at 1. Issue wins, because it represents a younger producer.
  - Issue and write to different registers: both take effect.
- Read, combinational, per port n:
  - ZERO_REG=1 and RSn=0: RDatan=0, RReadyn=1.
  - Otherwise, if BYPASS=1, RegWrite=1 and RD=RSn (and RD not the zero register): RDatan=WData, RReadyn=1. This holds even if Busy[RSn]=1.
  - Otherwise: RDatan=Reg[RSn], RReadyn=~Busy[RSn].
  - BYPASS=0: a read of a register written this cycle returns the old value. RReady follows Busy only, so a busy register stays not-ready until the cycle after its write.
- Issue in the current cycle does not affect current-cycle RReady. It is visible from the next cycle.
- StallReq: purely combinational from RUse/RReady as listed under Ports. No latency.
- BusyCount: registered popcount of Busy after the update. Latency 1 cycle from issue/write. Range 0..2**ADDR_W (max 2**ADDR_W-1 when ZERO_REG=1).
- Redundant operations:
  - Issue to an already-busy register: Busy stays 1, count unchanged.
  - Write to a non-busy register: normal write, count unchanged.
- Out-of-range addresses do not exist; all ADDR_W codes are valid.

Test Plan:
- Reset: hold Reset_n=0, pulse Clk with RegWrite=1, RD=3, WData=0xDEAD -> Reg[3] reads 0, RReady1/2=1, BusyCount=0. Release reset, write 0xDEAD to r3 -> RData1=0xDEAD next cycle with RS1=3.
- Zero register: RegWrite=1, RD=0, WData=0xFFFFFFFF; IssueEn=1, IssueRD=0 -> RS1=0 gives RData1=0, RReady1=1, BusyCount stays 0.
- Scoreboard stall: issue r5 at cycle 0. At cycle 1, RS2=5, RUse2=1 -> RReady2=0, StallReq=1, BusyCount=1. Writeback r5=0x1234 at cycle 3 -> with BYPASS=1, RData2=0x1234, RReady2=1, StallReq=0 in cycle 3; BusyCount=0 at cycle 4. With BYPASS=0, stall persists in cycle 3 and clears in cycle 4 with RData2=0x1234.
- Simultaneous issue and write: r7 busy; same cycle RegWrite r7=0xAA and IssueEn r7 -> next cycle Reg[7]=0xAA, RReady1 (RS1=7)=0, BusyCount unchanged.
- Dual port and unused operand: r2 busy, r4 ready=0x44; RS1=2 with RUse1=0, RS2=4 with RUse2=1 -> StallReq=0, RData2=0x44. Set RUse1=1 -> StallReq=1.
- Asynchronous reset mid-operation: 3 registers busy, assert Reset_n low between clock edges -> Busy cleared immediately; BusyCount=0 and StallReq=0 without a clock edge.
